// File: rtl/axil_mem_fill.sv
// AXI4-Lite memory fill master: writes word_count words from base_addr.
// Define AXIL_MEM_FILL_INCR_EN to write pattern+i instead of a constant.
module axil_mem_fill #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_RESP,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    state_t r_state;
    state_t w_next;

    logic                  r_aw_ok;
    logic                  r_w_ok;
    logic                  r_abort;
    logic                  r_error;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_left;
    logic [DATA_WIDTH-1:0] r_data;

    logic w_start;
    logic w_busy;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_both;
    logic w_b_hs;
    logic w_b_err;
    logic w_stop;
    logic w_advance;

    assign w_start   = (r_state == S_IDLE) && start;
    assign w_busy    = (r_state == S_WRITE) || (r_state == S_RESP);
    assign w_aw_hs   = m_axil_awvalid && m_axil_awready;
    assign w_w_hs    = m_axil_wvalid && m_axil_wready;
    assign w_both    = (r_aw_ok || w_aw_hs) && (r_w_ok || w_w_hs);
    assign w_b_hs    = (r_state == S_RESP) && m_axil_bvalid;
    assign w_b_err   = (m_axil_bresp != 2'b00);
    // An abort arriving with the B handshake still ends this fill once.
    assign w_stop    = r_abort || abort || (r_left == '0);
    assign w_advance = w_b_hs && !w_b_err && !w_stop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (word_count == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_both) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (w_b_hs) begin
                    w_next = w_advance ? S_WRITE : S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy           = w_busy;
        done           = (r_state == S_DONE);
        error          = r_error;
        m_axil_awaddr  = r_addr;
        m_axil_awprot  = 3'b000;
        m_axil_awvalid = (r_state == S_WRITE) && !r_aw_ok;
        m_axil_wdata   = r_data;
        m_axil_wstrb   = '1;
        m_axil_wvalid  = (r_state == S_WRITE) && !r_w_ok;
        m_axil_bready  = (r_state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aw_ok <= 1'b0;
            r_w_ok  <= 1'b0;
            r_abort <= 1'b0;
            r_error <= 1'b0;
            r_addr  <= '0;
            r_left  <= '0;
            r_data  <= '0;
        end else if (w_start) begin
            r_aw_ok <= 1'b0;
            r_w_ok  <= 1'b0;
            r_abort <= 1'b0;
            r_error <= 1'b0;
            r_addr  <= base_addr & ALIGN_MASK;
            r_left  <= word_count - ADDR_WIDTH'(1);
            r_data  <= pattern;
        end else begin
            if (w_busy && abort) begin
                r_abort <= 1'b1;
            end
            if (w_aw_hs) begin
                r_aw_ok <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_ok <= 1'b1;
            end
            if (w_b_hs && w_b_err) begin
                r_error <= 1'b1;
            end
            if (w_advance) begin
                r_aw_ok <= 1'b0;
                r_w_ok  <= 1'b0;
                r_left  <= r_left - ADDR_WIDTH'(1);
                r_addr  <= r_addr + ADDR_WIDTH'(STRB_WIDTH);
`ifdef AXIL_MEM_FILL_INCR_EN
                r_data  <= r_data + DATA_WIDTH'(1);
`else
                r_data  <= r_data;
`endif
            end
        end
    end

endmodule

// File: doc/axil_mem_fill.md
AXIL_MEM_FILL -- requirements
Module: axil_mem_fill

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI4-Lite data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, AXI4-Lite address width in bits.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write strobe width.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a fill.
REQ-007 SHALL have port abort  in  1  stop the fill after the in-flight word.
REQ-008 SHALL have port base_addr  in  ADDR_WIDTH  byte address of the first word.
REQ-009 SHALL have port word_count  in  ADDR_WIDTH  number of words to write.
REQ-010 SHALL have port pattern  in  DATA_WIDTH  fill data seed.
REQ-011 SHALL have port busy  out  1  fill in progress.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port error  out  1  sticky error flag, cleared by the next accepted start.
REQ-014 SHALL have port m_axil_awaddr  out  ADDR_WIDTH  write address.
REQ-015 SHALL have port m_axil_awprot  out  3  constant 3'b000.
REQ-016 SHALL have port m_axil_awvalid / m_axil_awready  out / in  1  AW handshake.
REQ-017 SHALL have port m_axil_wdata  out  DATA_WIDTH  write data.
REQ-018 SHALL have port m_axil_wstrb  out  STRB_WIDTH  constant all-ones.
REQ-019 SHALL have port m_axil_wvalid / m_axil_wready  out / in  1  W handshake.
REQ-020 SHALL have port m_axil_bresp  in  2  write response.
REQ-021 SHALL have port m_axil_bvalid / m_axil_bready  in / out  1  B handshake.

Function
REQ-022 SHALL implement states IDLE -> WRITE -> RESP -> (WRITE | DONE) -> IDLE.
REQ-023 SHALL act on start only in IDLE; start while busy is ignored; start at edge T puts awvalid and wvalid high from T+1.
REQ-024 SHALL assert busy from the cycle after an accepted start until done.
REQ-025 SHALL, for word_count=0, pulse done at T+1 with no AXI traffic and leave busy low.
REQ-026 SHALL address word i at {base_addr aligned down to STRB_WIDTH bytes} + i*STRB_WIDTH, modulo 2^ADDR_WIDTH, with wrap-around permitted.
REQ-027 SHALL assert awvalid and wvalid in the same cycle on WRITE entry.
REQ-028 SHALL drop each valid individually after its own handshake, keeping awaddr and wdata stable while the valid is high.
REQ-029 SHALL enter RESP once both handshakes complete.
REQ-030 SHALL hold bready high only in RESP, with at most one transaction outstanding.
REQ-031 SHALL, on B handshake with bresp=00, advance to the next word, or to DONE after word word_count-1.
REQ-032 SHALL, on bresp!=00, set error and go to DONE, issuing no further writes.
REQ-033 SHALL latch abort whenever busy; the in-flight word completes through B, then DONE.
REQ-034 SHALL, in DONE, pulse done for exactly one cycle with busy low in that cycle, then return to IDLE.
REQ-035 SHALL, when abort and the final B handshake coincide, give a single DONE.

Reset
REQ-036 SHALL, at a rising clk edge with rst_n=0, force IDLE, awvalid=wvalid=bready=0, busy=0, done=0, error=0, and abandon any in-flight transfer.

Configuration
REQ-037 SHALL, with macro AXIL_MEM_FILL_INCR_EN defined, write wdata = pattern + i mod 2^DATA_WIDTH, and without it write wdata = pattern for every word.

Verification
REQ-038 SHALL cover: INCR on, base=0x0100, count=4, pattern=0xA5A50000, always-ready slave -> writes 0x0100/04/08/0C with 0xA5A50000..03, then one done pulse, error=0.
REQ-039 SHALL cover: count=0 -> done at T+1, awvalid never high, busy stays 0.
REQ-040 SHALL cover: base=0xFFF8, count=4 -> awaddr 0xFFF8, 0xFFFC, 0x0000, 0x0004.
REQ-041 SHALL cover: bresp=2'b10 on word 1 -> exactly 2 writes, error=1, done pulse.
REQ-042 SHALL cover: wready immediate, awready delayed 5 cycles -> wvalid drops after 1 cycle, awvalid holds with stable address, bready rises only after AW.
REQ-043 SHALL cover: rst_n=0 mid-WRITE -> next cycle all valids 0, busy 0, and a following start with count=1 completes normally.
